byte_dual_ram: RTL and testbench
================================

# byte_dual_ram

Parametrised simple dual-port RAM (one write port, one read port) with per-byte write enables, byte-granular write-to-read forwarding, a hardware clear sweep after reset, and a read-valid strobe. It serves as instruction/data memory for the 3-stage RISC-V core: the loader or store path drives the write port and the fetch/load path drives the read port. Memory is word-addressed; each address holds one DATA_WIDTH-bit word.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, bits per write-enable lane
- ADDR_WIDTH, 12, address width
- MEM_BLOCKS, 4096, number of words; must be ≤ 2^ADDR_WIDTH
- sys_clk  in  1  clock; all logic is on the rising edge
- sys_rst  in  1  reset; synchronous, active-high
- wen  in  1  write request
- w_addr  in  ADDR_WIDTH  write word address
- w_data  in  DATA_WIDTH  write data
- w_be  in  DATA_WIDTH/BYTE_WIDTH  byte-lane enables; lane i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH]
- ren  in  1  read request
- r_addr  in  ADDR_WIDTH  read word address
- r_data  out  DATA_WIDTH  read data
- r_valid  out  1  r_data carries the result of an accepted read
- init_busy  out  1  clear sweep in progress; requests are ignored while high

## Operation
- **States:** CLEAR and RUN.
- **Reset:** sys_rst high forces state CLEAR and sweep counter 0. Outputs reset to r_data=0, r_valid=0, init_busy=1. Reset mid-sweep or mid-run restarts the sweep from address 0.
- **CLEAR:**
  - Writes 0 to address cnt each cycle, then increments cnt.
  - After writing MEM_BLOCKS-1, moves to RUN. init_busy drops in the first RUN cycle.
  - wen and ren are ignored. r_valid stays 0 and r_data holds.
- **Write (RUN):** when wen=1 and w_addr < MEM_BLOCKS, updates only the lanes with w_be[i]=1. wen with w_be=0 is a no-op. Out-of-range writes are dropped.
- **Read (RUN):**
  - When ren=1, the word at r_addr is captured into r_data and r_valid is set for one cycle.
  - When ren=0, r_data holds its last value and r_valid=0.
  - An out-of-range r_addr returns 0 with r_valid=1.
- **Forwarding:** when wen, ren and w_addr==r_addr happen in the same cycle, the returned word is built per lane:
  - lanes with w_be set take the new w_data;
  - all other lanes take the old stored value.
  - Memory is updated in the same edge.
- **Sequential access:** a read issued the cycle after a write to the same address returns the written value naturally; no extra forwarding is needed.

## Timing
- Read latency is 1 cycle (ren at edge N produces r_data/r_valid valid after edge N+1), or 2 cycles with the output register enabled.
- Clear sweep takes exactly MEM_BLOCKS cycles after reset deasserts. The first request is accepted in cycle MEM_BLOCKS (counting cycle 0 as the first non-reset cycle).
- One read and one write can be accepted per cycle. There is no backpressure.
- r_valid is high for exactly one cycle per accepted read. Back-to-back reads give continuous r_valid.

## Configuration
- **BYTE_DUAL_RAM_OUT_REG_EN defined:**
  - r_data and r_valid pass through an additional pipeline register, so latency is 2.
  - The forwarded merge is captured in stage 1, so forwarding is unchanged.
  - Reset clears both stages.
  - The stage-2 r_data holds when its input is not valid.
- **Not defined:** single register stage, latency 1.

## Structure
- Package byte_dual_ram_pkg holds:
  - the state enum (CLEAR, RUN);
  - the lane-count constant NB = DATA_WIDTH/BYTE_WIDTH;
  - the byte-merge function (old word, new word, enables → merged word), shared by the write path and the forwarding path.
- Sub-module ram_clear_fsm holds the state register, the sweep counter and the init_busy output. It supplies the clear write address and write enable, which are muxed ahead of the user write port.

## Test plan
- **Reset and clear sweep:** reset for 3 cycles, release. init_busy stays 1 for exactly MEM_BLOCKS cycles. A ren to address 5 during the sweep gives r_valid=0. After the sweep, reading addresses 0, 5 and 4095 returns 0x00000000.
- **Byte enables:**
  - Write 0xDEADBEEF to address 0x010 with w_be=4'b1111.
  - Write 0x11223344 to 0x010 with w_be=4'b0101.
  - Read 0x010: returns 0xDE22BE44 one cycle later with r_valid=1.
- **Same-cycle forwarding:**
  - Address 0x020 holds 0xAAAAAAAA.
  - In one cycle, write 0x12345678 with w_be=4'b0011 and read 0x020.
  - r_data=0xAAAA5678. A next-cycle read returns the same value.
- **Hold and out-of-range:** ren=0 for 4 cycles keeps r_data unchanged with r_valid=0. With ADDR_WIDTH=12 and MEM_BLOCKS=3000, reading 3500 returns 0 and writing 3500 alters nothing.
- **Reset mid-sweep:** at sweep count 100, pulse sys_rst. The sweep restarts at 0, and init_busy lasts a full MEM_BLOCKS cycles after the release.
- **With BYTE_DUAL_RAM_OUT_REG_EN:** back-to-back reads of 0x001, 0x002 and 0x003 give r_valid high for 3 cycles starting 2 cycles after the first ren, with data in order. The forwarding case above gives the same 0xAAAA5678.

Source files
------------

// File: rtl/byte_dual_ram_pkg.sv
// Shared types and helpers for byte_dual_ram: FSM state encoding, default lane
// count and the byte-lane merge used by both the write path and the
// same-cycle read forwarding path.
package byte_dual_ram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BYTE_WIDTH = 8;
  localparam int NB             = DEF_DATA_WIDTH / DEF_BYTE_WIDTH;

  // Widest word the merge helper handles; callers zero-extend into it.
  localparam int MAX_WIDTH = 256;

  // Bit j of the result comes from new_word when the enable of its lane
  // (j / byte_width) is set, otherwise from old_word. Enables above the
  // caller's lane count are zero-extended so they never select anything.
  function automatic logic [MAX_WIDTH-1:0] byte_merge(
    input logic [MAX_WIDTH-1:0] old_word,
    input logic [MAX_WIDTH-1:0] new_word,
    input logic [MAX_WIDTH-1:0] be,
    input int                   byte_width
  );
    logic [MAX_WIDTH-1:0] merged;
    merged = old_word;
    for (int j = 0; j < MAX_WIDTH; j++) begin
      if (be[j / byte_width]) begin
        merged[j] = new_word[j];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/byte_dual_ram_clear_fsm.sv
// Clear-sweep sequencer for byte_dual_ram. After reset it walks every word
// address once, asserting a write of zero each cycle, then parks in RUN.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   CLEAR | sweep in progress; clr_addr is zeroed this cycle, user idle
//   RUN   | sweep done; user read/write ports are live
module ram_clear_fsm
  import byte_dual_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int MEM_BLOCKS = 4096
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  init_busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_BLOCKS - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;

  assign clr_addr = cnt;

  // State, sweep counter and registered busy/write-enable flags.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= CLEAR;
      cnt       <= '0;
      clr_we    <= 1'b1;
      init_busy <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (cnt == LAST_ADDR) begin
            state     <= RUN;
            cnt       <= '0;
            clr_we    <= 1'b0;
            init_busy <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          clr_we    <= 1'b0;
          init_busy <= 1'b0;
        end
        default: begin
          state     <= CLEAR;
          cnt       <= '0;
          clr_we    <= 1'b1;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/byte_dual_ram.sv
// Simple dual-port word RAM with per-byte write enables, same-cycle
// write-to-read forwarding, a zeroing sweep after reset and a read-valid
// strobe. Optional build macro BYTE_DUAL_RAM_OUT_REG_EN adds a second output
// register stage (read latency 2 instead of 1).
module byte_dual_ram
  import byte_dual_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int MEM_BLOCKS = 4096
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst,
  input  logic                             wen,
  input  logic [ADDR_WIDTH-1:0]            w_addr,
  input  logic [DATA_WIDTH-1:0]            w_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] w_be,
  input  logic                             ren,
  input  logic [ADDR_WIDTH-1:0]            r_addr,
  output logic [DATA_WIDTH-1:0]            r_data,
  output logic                             r_valid,
  output logic                             init_busy
);

  localparam int          LANES     = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BLOCKS);

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [LANES-1:0]      be
  );
    return DATA_WIDTH'(byte_merge(MAX_WIDTH'(old_word), MAX_WIDTH'(new_word),
                                  MAX_WIDTH'(be), BYTE_WIDTH));
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_BLOCKS];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  run;

  logic                  w_in_range;
  logic                  r_in_range;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [LANES-1:0]      mem_be;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] stored_word;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_valid;

  ram_clear_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_BLOCKS (MEM_BLOCKS)
  ) u_clear_fsm (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_busy (init_busy)
  );

  assign run        = ~init_busy;
  assign w_in_range = 32'(w_addr) < MEM_LIMIT;
  assign r_in_range = 32'(r_addr) < MEM_LIMIT;

  // Write-port mux: the clear sweep owns the array until it finishes.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = w_addr;
    mem_wdata = w_data;
    mem_be    = w_be;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr;
      mem_wdata = '0;
      mem_be    = '1;
    end else if (run && wen && w_in_range && (|w_be)) begin
      mem_we = 1'b1;
    end
  end

  // Read word with lane-wise forwarding of a same-address write in flight.
  always_comb begin
    stored_word = '0;
    if (r_in_range) begin
      stored_word = mem[r_addr];
    end
    fwd_hit = wen && w_in_range && (w_addr == r_addr);
    rd_word = stored_word;
    if (fwd_hit) begin
      rd_word = merge_lanes(stored_word, w_data, w_be);
    end
  end

  // Array update; only enabled lanes change.
  always_ff @(posedge sys_clk) begin
    if (mem_we) begin
      mem[mem_addr] <= merge_lanes(mem[mem_addr], mem_wdata, mem_be);
    end
  end

  // First output stage: capture accepted reads, hold data otherwise.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= run && ren;
      if (run && ren) begin
        s1_data <= rd_word;
      end
    end
  end

`ifdef BYTE_DUAL_RAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] s2_data;
  logic                  s2_valid;

  // Second output stage: delays the strobe, reloads data only on valid.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s2_data  <= '0;
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= s1_data;
      end
    end
  end

  assign r_data  = s2_data;
  assign r_valid = s2_valid;
`else
  assign r_data  = s1_data;
  assign r_valid = s1_valid;
`endif

endmodule

// File: tb/tb_byte_dual_ram.sv
// Self-checking bench for byte_dual_ram (MEM_BLOCKS=3000 so out-of-range
// addresses exist). Honors BYTE_DUAL_RAM_OUT_REG_EN for the read latency.
module tb_byte_dual_ram;
  import byte_dual_ram_pkg::*;

  localparam int MB = 3000;
`ifdef BYTE_DUAL_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic        we;
    logic [11:0] wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        re;
    logic [11:0] ra;
  } op_t;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          wen;
  logic [11:0]   w_addr;
  logic [31:0]   w_data;
  logic [NB-1:0] w_be;
  logic          ren;
  logic [11:0]   r_addr;
  logic [31:0]   r_data;
  logic          r_valid;
  logic          init_busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [MB];
  logic [31:0] hold_data;
  logic        q_valid [$];
  logic [31:0] q_data  [$];

  always #5 sys_clk = ~sys_clk;

  byte_dual_ram #(
    .DATA_WIDTH (32),
    .BYTE_WIDTH (8),
    .ADDR_WIDTH (12),
    .MEM_BLOCKS (MB)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .wen       (wen),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .w_be      (w_be),
    .ren       (ren),
    .r_addr    (r_addr),
    .r_data    (r_data),
    .r_valid   (r_valid),
    .init_busy (init_busy)
  );

  function automatic op_t mk(input logic we, input logic [11:0] wa, input logic [31:0] wd,
                             input logic [3:0] be, input logic re, input logic [11:0] ra);
    op_t o;
    o.we = we; o.wa = wa; o.wd = wd; o.be = be; o.re = re; o.ra = ra;
    return o;
  endfunction

  function automatic op_t idle_op();
    return mk(1'b0, 12'd0, 32'd0, 4'd0, 1'b0, 12'd0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < MB; i++) model_mem[i] = 32'd0;
    hold_data = 32'd0;
    q_valid.delete();
    q_data.delete();
  endtask

  // Drives one cycle, advances the reference model and returns the observed
  // outputs along with the expectation that is due this cycle (if any).
  task automatic step(input op_t op, output logic chk, output logic ov, output logic [31:0] od,
                      output logic ev, output logic [31:0] ed);
    logic [31:0] word;
    @(negedge sys_clk);
    wen = op.we; w_addr = op.wa; w_data = op.wd; w_be = op.be;
    ren = op.re; r_addr = op.ra;
    if (op.re) begin
      word = 32'd0;
      if (op.ra < MB) word = model_mem[op.ra];
      if (op.we && op.wa < MB && op.wa == op.ra)
        for (int b = 0; b < 4; b++) if (op.be[b]) word[b*8 +: 8] = op.wd[b*8 +: 8];
      hold_data = word;
      q_valid.push_back(1'b1);
      q_data.push_back(word);
    end else begin
      q_valid.push_back(1'b0);
      q_data.push_back(hold_data);
    end
    if (op.we && op.wa < MB)
      for (int b = 0; b < 4; b++) if (op.be[b]) model_mem[op.wa][b*8 +: 8] = op.wd[b*8 +: 8];
    @(posedge sys_clk);
    #1;
    ov = r_valid;
    od = r_data;
    chk = 1'b0; ev = 1'b0; ed = 32'd0;
    if (q_valid.size() >= LAT) begin
      chk = 1'b1;
      ev = q_valid.pop_front();
      ed = q_data.pop_front();
    end
  endtask

  task automatic test_reset();
    int   n;
    logic saw_valid;
    logic chk, ov, ev;
    logic [31:0] od, ed;
    op_t ops [$];
    sys_rst = 1'b1; wen = 1'b0; ren = 1'b0; w_addr = '0; w_data = '0; w_be = '0; r_addr = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    n_assert++;
    if (r_valid !== 1'b0 || r_data !== 32'd0 || init_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b data=%h busy=%b, want 0 00000000 1",
               r_valid, r_data, init_busy);
    end
    @(negedge sys_clk);
    sys_rst = 1'b0; ren = 1'b1; r_addr = 12'd5;
    model_reset();
    n = 0; saw_valid = 1'b0;
    while (init_busy === 1'b1 && n < MB + 50) begin
      n++;
      @(posedge sys_clk);
      #1;
      if (r_valid !== 1'b0) saw_valid = 1'b1;
    end
    n_assert++;
    if (n !== MB) begin
      n_fail++;
      $display("FAIL sweep_len: got %0d busy cycles, want %0d", n, MB);
    end
    n_assert++;
    if (saw_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_ren_ignored: got r_valid=1 during sweep, want 0");
    end
    ops.push_back(mk(1'b0, 12'd0, 32'd0, 4'd0, 1'b1, 12'd0));
    ops.push_back(mk(1'b0, 12'd0, 32'd0, 4'd0, 1'b1, 12'd5));
    ops.push_back(mk(1'b0, 12'd0, 32'd0, 4'd0, 1'b1, 12'd4095));
    ops.push_back(mk(1'b0, 12'd0, 32'd0, 4'd0, 1'b1, 12'd2999));
    ops.push_back(idle_op());
    ops.push_back(idle_op());
    foreach (ops[i]) begin
      step(ops[i], chk, ov, od, ev, ed);
      if (chk) begin
        n_assert++;
        if (ov !== ev || od !== ed) begin
          n_fail++;
          $display("FAIL cleared_read[%0d]: got valid=%b data=%h, want valid=%b data=%h",
                   i, ov, od, ev, ed);
        end
      end
    end
  endtask

  task automatic test_byte_enables();
    logic chk, ov, ev;
    logic [31:0] od, ed;
    op_t ops [$];
    ops.push_back(mk(1'b1, 12'h010, 32'hDEADBEEF, 4'b1111, 1'b0, 12'd0));
    ops.push_back(mk(1'b1, 12'h010, 32'h11223344, 4'b0101, 1'b0, 12'd0));
    ops.push_back(mk(1'b1, 12'h010, 32'hFFFFFFFF, 4'b0000, 1'b0, 12'd0));
    ops.push_back(mk(1'b0, 12'd0, 32'd0, 4'd0, 1'b1, 12'h010));
    ops.push_back(idle_op());
    ops.push_back(idle_op());
    foreach (ops[i]) begin
      step(ops[i], chk, ov, od, ev, ed);
      if (chk) begin
        n_assert++;
        if (ov !== ev || od !== ed || (ev === 1'b1 && od !== 32'hDE22BE44)) begin
          n_fail++;
          $display("FAIL byte_enable[%0d]: got valid=%b data=%h, want valid=%b data=%h",
                   i, ov, od, ev, ed);
        end
      end
    end
  endtask

  task automatic test_forwarding();
    logic chk, ov, ev;
    logic [31:0] od, ed;
    op_t ops [$];
    ops.push_back(mk(1'b1, 12'h020, 32'hAAAAAAAA, 4'b1111, 1'b0, 12'd0));
    ops.push_back(mk(1'b1, 12'h020, 32'h12345678, 4'b0011, 1'b1, 12'h020));
    ops.push_back(mk(1'b0, 12'd0, 32'd0, 4'd0, 1'b1, 12'h020));
    ops.push_back(idle_op());
    ops.push_back(idle_op());
    foreach (ops[i]) begin
      step(ops[i], chk, ov, od, ev, ed);
      if (chk) begin
        n_assert++;
        if (ov !== ev || od !== ed || (ev === 1'b1 && od !== 32'hAAAA5678)) begin
          n_fail++;
          $display("FAIL forward[%0d]: got valid=%b data=%h, want valid=%b data=%h",
                   i, ov, od, ev, ed);
        end
      end
    end
  endtask

  task automatic test_hold_oor();
    logic chk, ov, ev;
    logic [31:0] od, ed;
    op_t ops [$];
    ops.push_back(mk(1'b0, 12'd0, 32'd0, 4'd0, 1'b1, 12'h010));
    repeat (4) ops.push_back(idle_op());
    ops.push_back(mk(1'b1, 12'd3500, 32'hCAFEF00D, 4'b1111, 1'b1, 12'd3500));
    ops.push_back(mk(1'b0, 12'd0, 32'd0, 4'd0, 1'b1, 12'd3500));
    ops.push_back(mk(1'b0, 12'd0, 32'd0, 4'd0, 1'b1, 12'd500));
    ops.push_back(mk(1'b0, 12'd0, 32'd0, 4'd0, 1'b1, 12'd452));
    ops.push_back(mk(1'b1, 12'd2999, 32'h0BADCAFE, 4'b1111, 1'b0, 12'd0));
    ops.push_back(mk(1'b0, 12'd0, 32'd0, 4'd0, 1'b1, 12'd2999));
    ops.push_back(mk(1'b0, 12'd0, 32'd0, 4'd0, 1'b1, 12'd3000));
    repeat (3) ops.push_back(idle_op());
    foreach (ops[i]) begin
      step(ops[i], chk, ov, od, ev, ed);
      if (chk) begin
        n_assert++;
        if (ov !== ev || od !== ed) begin
          n_fail++;
          $display("FAIL hold_oor[%0d]: got valid=%b data=%h, want valid=%b data=%h",
                   i, ov, od, ev, ed);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic chk, ov, ev;
    logic [31:0] od, ed;
    int run_len = 0;
    int max_run = 0;
    op_t ops [$];
    ops.push_back(mk(1'b1, 12'h001, 32'h01010101, 4'b1111, 1'b0, 12'd0));
    ops.push_back(mk(1'b1, 12'h002, 32'h02020202, 4'b1111, 1'b0, 12'd0));
    ops.push_back(mk(1'b1, 12'h003, 32'h03030303, 4'b1111, 1'b0, 12'd0));
    ops.push_back(mk(1'b0, 12'd0, 32'd0, 4'd0, 1'b1, 12'h001));
    ops.push_back(mk(1'b0, 12'd0, 32'd0, 4'd0, 1'b1, 12'h002));
    ops.push_back(mk(1'b0, 12'd0, 32'd0, 4'd0, 1'b1, 12'h003));
    repeat (3) ops.push_back(idle_op());
    foreach (ops[i]) begin
      step(ops[i], chk, ov, od, ev, ed);
      if (ov === 1'b1) run_len++; else run_len = 0;
      if (run_len > max_run) max_run = run_len;
      if (chk) begin
        n_assert++;
        if (ov !== ev || od !== ed) begin
          n_fail++;
          $display("FAIL back_to_back[%0d]: got valid=%b data=%h, want valid=%b data=%h",
                   i, ov, od, ev, ed);
        end
      end
    end
    n_assert++;
    if (max_run !== 3) begin
      n_fail++;
      $display("FAIL back_to_back_valid_run: got %0d consecutive valid cycles, want 3", max_run);
    end
  endtask

  task automatic test_random();
    logic chk, ov, ev;
    logic [31:0] od, ed;
    op_t o;
    for (int i = 0; i < 400; i++) begin
      o.we = 1'($urandom_range(0, 1));
      o.wa = ($urandom_range(0, 9) < 8) ? 12'($urandom_range(0, 15)) : 12'($urandom_range(2990, 3010));
      o.wd = $urandom;
      o.be = 4'($urandom_range(0, 15));
      o.re = 1'($urandom_range(0, 1));
      o.ra = ($urandom_range(0, 9) < 8) ? 12'($urandom_range(0, 15)) : 12'($urandom_range(2990, 3010));
      if ($urandom_range(0, 3) == 0) o.ra = o.wa;
      step(o, chk, ov, od, ev, ed);
      if (chk) begin
        n_assert++;
        if (ov !== ev || od !== ed) begin
          n_fail++;
          $display("FAIL random[%0d]: got valid=%b data=%h, want valid=%b data=%h",
                   i, ov, od, ev, ed);
        end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int   n;
    logic saw_valid;
    logic chk, ov, ev;
    logic [31:0] od, ed;
    op_t ops [$];
    @(negedge sys_clk);
    sys_rst = 1'b1; wen = 1'b0; ren = 1'b0;
    repeat (2) @(negedge sys_clk);
    n_assert++;
    if (r_data !== 32'd0 || r_valid !== 1'b0 || init_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rerun_reset_state: got valid=%b data=%h busy=%b, want 0 00000000 1",
               r_valid, r_data, init_busy);
    end
    sys_rst = 1'b0;
    repeat (100) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0; ren = 1'b1; r_addr = 12'h010;
    model_reset();
    n = 0; saw_valid = 1'b0;
    while (init_busy === 1'b1 && n < MB + 50) begin
      n++;
      @(posedge sys_clk);
      #1;
      if (r_valid !== 1'b0) saw_valid = 1'b1;
    end
    n_assert++;
    if (n !== MB || saw_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_sweep_restart: got %0d busy cycles valid_seen=%b, want %0d and 0",
               n, saw_valid, MB);
    end
    ops.push_back(mk(1'b0, 12'd0, 32'd0, 4'd0, 1'b1, 12'h010));
    ops.push_back(mk(1'b0, 12'd0, 32'd0, 4'd0, 1'b1, 12'h020));
    ops.push_back(mk(1'b0, 12'd0, 32'd0, 4'd0, 1'b1, 12'd2999));
    ops.push_back(mk(1'b1, 12'h030, 32'h5A5A5A5A, 4'b1001, 1'b1, 12'h030));
    ops.push_back(idle_op());
    ops.push_back(idle_op());
    foreach (ops[i]) begin
      step(ops[i], chk, ov, od, ev, ed);
      if (chk) begin
        n_assert++;
        if (ov !== ev || od !== ed) begin
          n_fail++;
          $display("FAIL post_rerun[%0d]: got valid=%b data=%h, want valid=%b data=%h",
                   i, ov, od, ev, ed);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_byte_enables();
    test_forwarding();
    test_hold_oor();
    test_back_to_back();
    test_random();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
